// File: rtl/iomem_arbiter.sv
// Two-master arbiter for the iomem peripheral register bus: one strobe per grant, read data returned with a ready pulse.
// Define IOMEM_ARBITER_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin.
`timescale 1ns/1ps
module iomem_arbiter #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              m0_valid,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ready,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_valid,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              s_valid,
   output logic              s_wr,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic [DATA_W-1:0] s_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] CNT_INIT = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

   state_t     state;
   logic       grant;
   logic [2:0] cnt;
   logic       pick_c;
   logic       resp_c;
`ifndef IOMEM_ARBITER_FIXED_PRIO_EN
   logic       last_grant;
`endif

   // Winner among the requesting masters (1 = master 1)
   always_comb begin
      pick_c = 1'b0;
`ifdef IOMEM_ARBITER_FIXED_PRIO_EN
      pick_c = !m0_valid;
`else
      if (m0_valid && m1_valid) pick_c = !last_grant;
      else                      pick_c = !m0_valid;
`endif
   end

   // Read data is valid on s_rdata in the last cycle before RESP
   always_comb begin
      resp_c = 1'b0;
      if (state == ISSUE && RD_LAT == 0) resp_c = 1'b1;
      if (state == WAIT && cnt == 3'd0)  resp_c = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= 1'b0;
`ifndef IOMEM_ARBITER_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
         cnt        <= 3'd0;
         s_valid    <= 1'b0;
         s_wr       <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         m0_ready   <= 1'b0;
         m1_ready   <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
         busy       <= 1'b0;
      end else begin
         s_valid  <= 1'b0;
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (m0_valid || m1_valid) begin
                  grant      <= pick_c;
`ifndef IOMEM_ARBITER_FIXED_PRIO_EN
                  last_grant <= pick_c;
`endif
                  s_valid    <= 1'b1;
                  s_wr       <= pick_c ? m1_wr    : m0_wr;
                  s_addr     <= pick_c ? m1_addr  : m0_addr;
                  s_wdata    <= pick_c ? m1_wdata : m0_wdata;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= CNT_INIT;
               state <= (RD_LAT == 0) ? RESP : WAIT;
            end
            WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd0) state <= RESP;
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (resp_c) begin
            if (grant) begin
               m1_ready <= 1'b1;
               m1_rdata <= s_wr ? '0 : s_rdata;
            end else begin
               m0_ready <= 1'b1;
               m0_rdata <= s_wr ? '0 : s_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Randomized scoreboard bench for iomem_arbiter, one harness per read latency (0, 1, 3, 7).
`timescale 1ns/1ps
module tb_iomem_arbiter;

   localparam int unsigned ADDR_W = 14;
   localparam int unsigned DATA_W = 32;
   localparam int N_CYC = 3000;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Power-on contents of the modelled peripheral register space
   function automatic logic [31:0] init_val(input logic [13:0] a);
      return ({18'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   typedef struct {
      int          c;
      bit          rdy;
      bit          m;
      bit          wr;
      logic [13:0] addr;
      logic [31:0] data;
   } ev_t;

   for (genvar g = 0; g < 4; g++) begin : h
      localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7;

      logic        reset_n;
      logic        m0_valid, m0_wr, m0_ready, m1_valid, m1_wr, m1_ready;
      logic [13:0] m0_addr, m1_addr, s_addr;
      logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
      logic        s_valid, s_wr, busy;

      iomem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(L)) dut (
         .clk(clk), .reset_n(reset_n),
         .m0_valid(m0_valid), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
         .m0_ready(m0_ready), .m0_rdata(m0_rdata),
         .m1_valid(m1_valid), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
         .m1_ready(m1_ready), .m1_rdata(m1_rdata),
         .s_valid(s_valid), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
         .s_rdata(s_rdata), .busy(busy)
      );

      ev_t         exp_q [$];
      int          busy_lo = -1;
      int          busy_hi = -2;
      logic [31:0] pmem [int];
      logic [31:0] rmem [int];
      int          pend_c = -1;
      logic [31:0] pend_d = '0;
      logic [13:0] pool [8];
      bit          req [2];
      bit          rwr [2];
      logic [13:0] raddr [2];
      logic [31:0] rwd [2];
      int          done_c [2];
      int          next_free = 0;
      bit          lg = 1'b1;

      // Peripheral: data appears on s_rdata only L cycles after the strobe, noise otherwise
      always @(negedge clk) begin
         if (s_valid) begin
            if (s_wr) pmem[int'(s_addr)] = s_wdata;
            pend_d = pmem.exists(int'(s_addr)) ? pmem[int'(s_addr)] : init_val(s_addr);
            pend_c = cyc + L;
         end
         s_rdata = (cyc == pend_c) ? pend_d : $urandom;
      end

      task automatic see(input bit rdy, input bit m, input logic [31:0] data);
         ev_t e;
         if (exp_q.size() == 0) begin
            e = '{c: -1, rdy: !rdy, m: !m, wr: 1'b0, addr: '0, data: '0};
         end else begin
            e = exp_q.pop_front();
         end
         check($sformatf("L%0d_%s_cycle", L, rdy ? "ready" : "strobe"), 64'(cyc), 64'(e.c));
         if (!rdy)
            check($sformatf("L%0d_strobe_payload", L), 64'({1'b0, s_wr, s_addr, s_wdata}),
                  64'({e.rdy, e.wr, e.addr, e.data}));
         else
            check($sformatf("L%0d_ready_m_rdata", L), 64'({1'b1, m, data}),
                  64'({e.rdy, e.m, e.data}));
      endtask

      // Monitor: every DUT strobe/ready must match the head of the expectation queue
      always @(negedge clk) begin
         while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            check($sformatf("L%0d_missed_event", L), 64'(cyc), 64'(exp_q[0].c));
            void'(exp_q.pop_front());
         end
         if (s_valid)  see(1'b0, 1'b0, 32'h0);
         if (m0_ready) see(1'b1, 1'b0, m0_rdata);
         if (m1_ready) see(1'b1, 1'b1, m1_rdata);
         check($sformatf("L%0d_busy", L), 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      end

      task automatic new_req(input int m);
         req[m]   = 1'b1;
         rwr[m]   = 1'($urandom_range(0, 1));
         raddr[m] = pool[$urandom_range(0, 7)];
         rwd[m]   = $urandom;
      endtask

      task automatic drive_pins();
         for (int m = 0; m < 2; m++)
            if (!req[m]) begin
               rwr[m]   = 1'($urandom_range(0, 1));
               raddr[m] = 14'($urandom);
               rwd[m]   = $urandom;
            end
         m0_valid = req[0]; m0_wr = rwr[0]; m0_addr = raddr[0]; m0_wdata = rwd[0];
         m1_valid = req[1]; m1_wr = rwr[1]; m1_addr = raddr[1]; m1_wdata = rwd[1];
      endtask

      // Stimulus and reference model: transaction-level view of grants and their timing
      initial begin : stim
         bit          v0, v1, p, rst_done;
         int          e;
         logic [31:0] xd;
         rst_done = 1'b0;
         reset_n  = 1'b0;
         for (int i = 0; i < 8; i++) pool[i] = 14'($urandom);
         pool[0]   = 14'h2004;
         req[0]    = 1'b1; rwr[0] = 1'b0; raddr[0] = pool[1]; rwd[0] = $urandom;
         req[1]    = 1'b1; rwr[1] = 1'b1; raddr[1] = 14'h2004; rwd[1] = 32'hCAFEF00D;
         done_c[0] = -1; done_c[1] = -1;
         drive_pins();
         repeat (3) @(negedge clk);
         check($sformatf("L%0d_reset_outputs", L),
               64'({s_valid, s_wr, s_addr, s_wdata, m0_ready, m1_ready, busy}), 64'(0));
         reset_n   = 1'b1;
         lg        = 1'b1;
         next_free = cyc + 1;
         for (int n = 0; n < N_CYC; n++) begin
            if (n > 0) @(negedge clk);
            if (!rst_done && cyc > 1500 && cyc >= busy_lo + ((L > 0) ? 1 : 0) && cyc < busy_hi) begin
               rst_done = 1'b1;
               #1 reset_n = 1'b0;
               #1;
               check($sformatf("L%0d_midreset_ctrl", L),
                     64'({s_valid, s_wr, s_addr, s_wdata, m0_ready, m1_ready, busy}), 64'(0));
               check($sformatf("L%0d_midreset_rdata", L), {m0_rdata, m1_rdata}, 64'(0));
               exp_q.delete();
               busy_lo = -1; busy_hi = -2;
               done_c[0] = -1; done_c[1] = -1;
               for (int m = 0; m < 2; m++) if (!req[m]) new_req(m);
               drive_pins();
               @(negedge clk);
               reset_n   = 1'b1;
               lg        = 1'b1;
               next_free = cyc + 1;
            end
            for (int m = 0; m < 2; m++)
               if (req[m] && done_c[m] == cyc) begin
                  req[m] = 1'b0;
                  done_c[m] = -1;
               end
            for (int m = 0; m < 2; m++)
               if (!req[m] && n < N_CYC - 50 && (cyc < 400 || $urandom_range(0, 99) < 35))
                  new_req(m);
            drive_pins();
            v0 = req[0] && done_c[0] < 0;
            v1 = req[1] && done_c[1] < 0;
            if (cyc + 1 >= next_free && (v0 || v1)) begin
`ifdef IOMEM_ARBITER_FIXED_PRIO_EN
               p = v0 ? 1'b0 : 1'b1;
`else
               if (v0 && v1) p = (lg == 1'b0) ? 1'b1 : 1'b0;
               else          p = v0 ? 1'b0 : 1'b1;
`endif
               lg = p;
               e  = cyc + 1;
               if (rwr[p]) begin
                  xd = 32'h0;
                  rmem[int'(raddr[p])] = rwd[p];
               end else begin
                  xd = rmem.exists(int'(raddr[p])) ? rmem[int'(raddr[p])] : init_val(raddr[p]);
               end
               exp_q.push_back('{c: e, rdy: 1'b0, m: p, wr: rwr[p], addr: raddr[p], data: rwd[p]});
               exp_q.push_back('{c: e + L + 1, rdy: 1'b1, m: p, wr: rwr[p], addr: raddr[p], data: xd});
               done_c[p] = e + L + 1;
               busy_lo   = e;
               busy_hi   = e + L + 1;
               next_free = e + L + 3;
            end
         end
         repeat (3) @(negedge clk);
         check($sformatf("L%0d_drain", L), 64'(exp_q.size()), 64'(0));
         done[g] = 1'b1;
      end
   end

   initial begin : summary
      bit all_done;
      all_done = 1'b0;
      for (int i = 0; i < 20000 && !all_done; i++) begin
         @(posedge clk);
         all_done = done[0] && done[1] && done[2] && done[3];
      end
      if (!all_done) check("harness_timeout", 64'(all_done), 64'(1));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
- Shares the single peripheral register bus (iomem: valid/wr/addr/wdata/rdata) between two requesters.
  - Master 0: SPI register bridge.
  - Master 1: on-chip register sequencer, e.g. a mode-change engine reprogramming video timing without MCU involvement.
- Grants one transaction at a time, presents it to the VIDC/video/cgmem decode for exactly one strobe cycle, captures read data after a fixed latency, and returns it to the winner with a ready pulse.
- Arbitration is round-robin by default.

Parameters:
- ADDR_W, 14, iomem byte address width.
- DATA_W, 32, iomem data width.
- RD_LAT, 1, cycles between the s_valid strobe and valid s_rdata. Legal range 0..7.

Ports:
- clk  in  1  system clock (sys_clk domain).
- reset_n  in  1  asynchronous active-low reset.
- m0_valid  in  1  master 0 request; held with fields stable until m0_ready.
- m0_wr  in  1  master 0 write (1) / read (0).
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ready  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  read data, valid while m0_ready=1.
- m1_valid, m1_wr, m1_addr, m1_wdata, m1_ready, m1_rdata: same as the master 0 ports, for master 1.
- s_valid  out  1  one-cycle bus strobe to peripheral decode.
- s_wr  out  1  bus write.
- s_addr  out  ADDR_W  bus address.
- s_wdata  out  DATA_W  bus write data.
- s_rdata  in  DATA_W  peripheral read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- **Reset** (async, reset_n=0):
  - State = IDLE.
  - All outputs 0: s_valid, s_wr, s_addr, s_wdata, m0/m1_ready, m0/m1_rdata, busy.
  - last_grant = 1, so master 0 wins the first tie.
  - Reset asserted mid-transaction aborts it: no ready is issued, and the master must re-request.
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Sample m0_valid/m1_valid at each edge.
  - Only one valid: grant it.
  - Both valid: grant the master not equal to last_grant.
  - On grant: latch wr/addr/wdata into the s_* registers, set grant/last_grant, go to ISSUE.
- **ISSUE:**
  - s_valid=1 for exactly this cycle.
  - RD_LAT=0: capture s_rdata at the end of this cycle and go to RESP.
  - RD_LAT>0: load a 3-bit counter with RD_LAT-1 and go to WAIT.
- **WAIT:**
  - s_valid=0; s_addr/s_wr/s_wdata held.
  - Counter decrements each cycle.
  - When the counter is 0, capture s_rdata and go to RESP.
- **RESP:**
  - mX_ready=1 for the granted master only, for exactly one cycle.
  - mX_rdata = captured data on reads, 0 on writes.
  - Next state is IDLE.
- **Timing:**
  - Latency from the valid-sampling edge to the ready cycle is RD_LAT+2 cycles.
  - Throughput is one transaction per RD_LAT+3 cycles.
- **Handshake rules:**
  - After mX_ready, a master drops valid or presents a new request. A valid still high in IDLE is treated as a new request.
  - The non-granted master's valid may change freely; it is ignored until IDLE.
- **Output hold:**
  - mX_rdata holds its last value after ready until overwritten.
  - s_addr/s_wr/s_wdata hold after the transaction.
  - s_wr is qualified only by s_valid.
- **Fairness:** under continuous contention grants strictly alternate 0,1,0,1.

Optional Feature:
- Macro: IOMEM_ARBITER_FIXED_PRIO_EN.
- Defined: master 0 (SPI) always wins a tie and last_grant is ignored. Master 1 can starve under continuous master-0 traffic, which is acceptable for debug bring-up.
- Undefined: round-robin as in Behaviour.
- All other timing is identical in both builds.

Test Plan:
1. Reset with m0_valid=1 asserted, then release → no activity until the first edge after release; s_valid pulses once. With RD_LAT=1 and s_rdata=32'h12345678, m0_ready is high exactly 3 cycles after the sampling edge and m0_rdata=32'h12345678.
2. m1 write, addr 14'h2004, wdata 32'hCAFEF00D → single s_valid cycle with s_wr=1, s_addr=14'h2004, s_wdata=32'hCAFEF00D; m1_ready pulses with m1_rdata=0; m0_ready stays 0.
3. Both masters hold valid for 4 transactions → grant order 0,1,0,1, with no gap beyond RD_LAT+3 cycles per transaction. With IOMEM_ARBITER_FIXED_PRIO_EN the order is 0,0,0,0.
4. m1 granted; m0 asserts valid during WAIT → m0 is served immediately after m1's RESP→IDLE, and m0 never receives a ready during m1's transaction.
5. reset_n pulsed low during WAIT → outputs clear asynchronously and no ready is issued. Re-requesting afterwards completes normally, with master 0 winning the tie.
6. Sweep RD_LAT ∈ {0,1,3,7} → ready latency is RD_LAT+2 cycles and rdata equals the s_rdata value sampled exactly RD_LAT cycles after s_valid.
